la_capture_core: RTL and testbench
==================================

Name: la_capture_core

Overview:
- Parametrised multi-channel logic-analyser capture engine; successor to the 2-channel fixed-rate sampler.
- Samples CH_NUM inputs on a programmable divided tick and waits for a programmable trigger (immediate / pattern / change).
- Packs samples into OUT_WIDTH-bit words, writes exactly cfg_words words to the downstream capture FIFO, then stops.
- Sits between the input pins and the capture FIFO read by the PicoRV32 host.

Parameters:
- CH_NUM, 2: number of sampled channels; OUT_WIDTH must be an integer multiple of CH_NUM.
- OUT_WIDTH, 8: FIFO word width; SPW = OUT_WIDTH/CH_NUM samples per word.
- DIV_WIDTH, 16: width of the sample-rate divider.
- CNT_WIDTH, 16: width of the word-count and overflow counters.

Ports:
- clk  in  1  system clock (only clock).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches config and arms; ignored unless IDLE.
- abort  in  1  one-cycle pulse; returns to IDLE from any state.
- cfg_div  in  DIV_WIDTH  tick every cfg_div+1 clocks.
- cfg_mode  in  2  0 immediate, 1 pattern match, 2 any change on masked channels, 3 reserved (treated as 0).
- cfg_trig_mask  in  CH_NUM  channels that participate in the trigger.
- cfg_trig_val  in  CH_NUM  pattern for mode 1.
- cfg_words  in  CNT_WIDTH  words to capture; 0 is treated as 1.
- din  in  CH_NUM  channels under analysis.
- dout  out  OUT_WIDTH  packed word; valid while fifo_wen=1.
- fifo_wen  out  1  one-cycle write strobe.
- fifo_full  in  1  downstream FIFO full.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- overflow  out  1  sticky; a word was dropped because fifo_full was high.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Input stage: din is registered once into din_s. All sampling and triggering use din_s, so din_s is 1 clk after din.
- Config: cfg_* are latched on start in IDLE and held until the next start. The overflow flag clears on start.
- Divider: counter runs only while busy and resets to 0 on entering ARMED. tick=1 when counter==cfg_div_l, and the counter then wraps to 0. With cfg_div=0, tick fires every clock. First tick occurs cfg_div+1 clocks after start.
- Change detection: din_p holds din_s from the previous tick (loaded on every tick in ARMED). Mode-2 condition is ((din_s^din_p)&mask)!=0. din_p is loaded with din_s on the first ARMED clock, so no false change fires at arming.
- Pattern condition (mode 1): ((din_s^val)&mask)==0.
- States:
  - IDLE: start -> ARMED.
  - ARMED: on a tick where the condition holds (mode 0 always holds) -> CAPTURE. The trigger sample is stored as sample 0.
  - CAPTURE: every tick stores one sample. After the word count reaches cfg_words -> DONE.
  - DONE: holds until start (-> ARMED) or abort (-> IDLE).
  - abort in any state -> IDLE, discards the partial word, and issues no fifo_wen. abort takes priority over start in the same cycle.
- Packing:
  - On each stored sample, shreg <= {shreg[OUT_WIDTH-CH_NUM-1:0], din_s}, so the newest sample is in the LSBs and the oldest in the MSBs.
  - A sample counter (0..SPW-1) wraps on the SPW-th sample, marking the word complete.
  - The completing sample is included in the word.
- Write: on word completion, next clock fifo_wen=1 with dout=completed word, for exactly 1 clk. dout holds its value until the next write.
- Full: if fifo_full=1 in the clock the write would issue:
  - fifo_wen stays 0 and the word is dropped;
  - overflow is set;
  - the word still counts toward cfg_words, so the capture length is bounded.
- Completion:
  - The word counter increments per completed word.
  - When it equals cfg_words_l (0 treated as 1): the state goes to DONE in the same clock that fifo_wen (or the drop) occurs.
  - Samples after that are ignored.
- Simultaneous events: start while busy is ignored. A tick with divider wrap and word completion in the same clock is handled normally, with no lost sample.
- Reset mid-capture: everything returns to reset values immediately; no partial write.

Optional Feature:
- Macro: LA_SYNC_EN.
- Defined: din passes through a 2-flop synchroniser before the din_s register, giving 3 clk input latency. Use for asynchronous external probes.
- Undefined: a single din_s register only, 1 clk latency.
- All other behaviour is identical; benches account for the latency via the same macro.

Test Plan (CH_NUM=2, OUT_WIDTH=8, SPW=4):
- Immediate capture: mode 0, cfg_div=0, cfg_words=2, din sequence 0,1,2,3,3,2,1,0 -> fifo_wen twice, dout=0x1B then 0xE4; done=1; busy=0.
- Divider: mode 0, cfg_div=3, cfg_words=1, din constant 2'b10 -> 4 ticks 4 clk apart; single write dout=0xAA; first tick 4 clk after start.
- Pattern trigger: mode 1, mask=2'b11, val=2'b11, cfg_div=0; din 0,1,2,3,0,0,0 -> no write before din_s=3; word=0xC0 (trigger sample 3 first).
- Change trigger: mode 2, mask=2'b01; din toggles bit1 only for 10 clk, then bit0 rises -> stays ARMED during the bit1 activity; triggers on the bit0 edge; 1 word written.
- Full/overflow: cfg_words=3, fifo_full=1 during the second write -> writes 1 and 3 only; overflow=1; done after 3 words; next start clears overflow.
- Abort/reset: abort after 2 samples in CAPTURE -> IDLE, no fifo_wen; repeat with rst_n low mid-capture -> all outputs 0 immediately.

Source files
------------

// File: rtl/la_capture_core.sv
// rtl/la_capture_core.sv - multi-channel logic-analyser capture engine (optional LA_SYNC_EN input synchroniser)
module la_capture_core #(
  parameter int CH_NUM    = 2,
  parameter int OUT_WIDTH = 8,
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [1:0]           cfg_mode,
  input  logic [CH_NUM-1:0]    cfg_trig_mask,
  input  logic [CH_NUM-1:0]    cfg_trig_val,
  input  logic [CNT_WIDTH-1:0] cfg_words,
  input  logic [CH_NUM-1:0]    din,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 fifo_wen,
  input  logic                 fifo_full,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int SPW = OUT_WIDTH / CH_NUM;
  localparam int SCW = (SPW > 1) ? $clog2(SPW) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               state;
  logic [CH_NUM-1:0]    din_s;
  logic [CH_NUM-1:0]    din_p;
  logic [DIV_WIDTH-1:0] cfg_div_l;
  logic [1:0]           cfg_mode_l;
  logic [CH_NUM-1:0]    cfg_trig_mask_l;
  logic [CH_NUM-1:0]    cfg_trig_val_l;
  logic [CNT_WIDTH-1:0] cfg_words_l;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [SCW-1:0]       samp_cnt;
  logic [CNT_WIDTH-1:0] word_cnt;
  logic [OUT_WIDTH-1:0] shreg;
  logic [OUT_WIDTH-1:0] word_next;
  logic                 first_armed;

  logic                 running;
  logic                 tick;
  logic                 trig_hit;
  logic                 store;
  logic                 word_last;
  logic                 final_word;
  logic [CNT_WIDTH-1:0] words_target;

`ifdef LA_SYNC_EN
  logic [CH_NUM-1:0] din_m1;
  logic [CH_NUM-1:0] din_m2;

  // Two-flop synchroniser followed by the sampling register (3 clk latency)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_m1 <= '0;
      din_m2 <= '0;
      din_s  <= '0;
    end else begin
      din_m1 <= din;
      din_m2 <= din_m1;
      din_s  <= din_m2;
    end
  end
`else
  // Single sampling register (1 clk latency)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_s <= '0;
    end else begin
      din_s <= din;
    end
  end
`endif

  // Newest sample enters the LSBs; a one-sample-per-word build just takes din_s
  if (SPW > 1) begin : g_shift
    assign word_next = {shreg[OUT_WIDTH-CH_NUM-1:0], din_s};
  end else begin : g_noshift
    assign word_next = din_s;
  end

  // Tick, trigger condition and word-completion decode
  always_comb begin
    running      = (state == S_ARMED) || (state == S_CAPTURE);
    tick         = running && (div_cnt == cfg_div_l);
    case (cfg_mode_l)
      2'd1:    trig_hit = (((din_s ^ cfg_trig_val_l) & cfg_trig_mask_l) == '0);
      // Arming clock only reloads din_p, so it can never see a change
      2'd2:    trig_hit = !first_armed && (((din_s ^ din_p) & cfg_trig_mask_l) != '0);
      default: trig_hit = 1'b1;
    endcase
    store        = tick && (((state == S_ARMED) && trig_hit) || (state == S_CAPTURE));
    word_last    = store && (samp_cnt == SCW'(SPW - 1));
    words_target = (cfg_words_l == '0) ? CNT_WIDTH'(1) : cfg_words_l;
    final_word   = word_last && ((word_cnt + CNT_WIDTH'(1)) == words_target);
  end

  // Capture FSM with registered status, packing and FIFO write outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
      fifo_wen        <= 1'b0;
      dout            <= '0;
      din_p           <= '0;
      cfg_div_l       <= '0;
      cfg_mode_l      <= '0;
      cfg_trig_mask_l <= '0;
      cfg_trig_val_l  <= '0;
      cfg_words_l     <= '0;
      div_cnt         <= '0;
      samp_cnt        <= '0;
      word_cnt        <= '0;
      shreg           <= '0;
      first_armed     <= 1'b0;
    end else begin
      fifo_wen <= 1'b0;
      if (abort) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        done        <= 1'b0;
        div_cnt     <= '0;
        samp_cnt    <= '0;
        word_cnt    <= '0;
        shreg       <= '0;
        first_armed <= 1'b0;
      end else if (start && ((state == S_IDLE) || (state == S_DONE))) begin
        cfg_div_l       <= cfg_div;
        cfg_mode_l      <= cfg_mode;
        cfg_trig_mask_l <= cfg_trig_mask;
        cfg_trig_val_l  <= cfg_trig_val;
        cfg_words_l     <= cfg_words;
        overflow        <= 1'b0;
        state           <= S_ARMED;
        busy            <= 1'b1;
        done            <= 1'b0;
        div_cnt         <= '0;
        samp_cnt        <= '0;
        word_cnt        <= '0;
        shreg           <= '0;
        first_armed     <= 1'b1;
      end else if (running) begin
        div_cnt     <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
        first_armed <= 1'b0;
        if ((state == S_ARMED) && (first_armed || tick)) begin
          din_p <= din_s;
        end
        if (store) begin
          shreg <= word_next;
          if (state == S_ARMED) begin
            state <= S_CAPTURE;
          end
          if (word_last) begin
            samp_cnt <= '0;
            word_cnt <= word_cnt + CNT_WIDTH'(1);
            // A full FIFO drops the word but it still counts toward the length
            if (fifo_full) begin
              overflow <= 1'b1;
            end else begin
              fifo_wen <= 1'b1;
              dout     <= word_next;
            end
            if (final_word) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            samp_cnt <= samp_cnt + SCW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_la_capture_core.sv
// tb/tb_la_capture_core.sv - scoreboard bench for la_capture_core (honours LA_SYNC_EN latency)
module tb_la_capture_core;

`ifdef LA_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_mode;
  logic [1:0]  cfg_trig_mask;
  logic [1:0]  cfg_trig_val;
  logic [15:0] cfg_words;
  logic [1:0]  din;
  logic [7:0]  dout;
  logic        fifo_wen;
  logic        fifo_full;
  logic        busy;
  logic        done;
  logic        overflow;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         errors;
  int         checks;
  int         cyc;
  logic [1:0] seq [0:39];
  logic [7:0] e_data [0:3];
  int         e_off [0:3];
  int         e_n;

  la_capture_core #(
    .CH_NUM(2), .OUT_WIDTH(8), .DIV_WIDTH(16), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_trig_mask(cfg_trig_mask),
    .cfg_trig_val(cfg_trig_val), .cfg_words(cfg_words), .din(din),
    .dout(dout), .fifo_wen(fifo_wen), .fifo_full(fifo_full),
    .busy(busy), .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write strobe pops one expected word and its cycle
  always @(negedge clk) begin
    if (fifo_wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write dout=%h cyc=%0d", dout, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (dout !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL write dout=%h cyc=%0d expected dout=%h cyc=%0d", dout, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [1:0] v);
    for (int i = 0; i < 40; i++) seq[i] = v;
  endtask

  task automatic expect_w(input logic [7:0] d, input int off);
    e_data[e_n] = d;
    e_off[e_n]  = off;
    e_n++;
  endtask

  // Step k of the run is the value present at start edge + k; seq[i] is lead by LAT-1 steps
  task automatic run(input int div, input int mode, input logic [1:0] mask, input logic [1:0] val,
                     input int words, input int full_lo, input int full_hi, input int abort_at,
                     input int nsteps);
    int k;
    int c0;
    cfg_div       = 16'(div);
    cfg_mode      = 2'(mode);
    cfg_trig_mask = mask;
    cfg_trig_val  = val;
    cfg_words     = 16'(words);
    for (int i = 0; i < nsteps + LAT - 1; i++) begin
      k         = i - (LAT - 1);
      din       = seq[i];
      start     = (k == 0);
      fifo_full = (k >= full_lo) && (k <= full_hi);
      abort     = (k == abort_at);
      @(posedge clk);
      #1;
      if (k == 0) begin
        c0 = cyc;
        for (int j = 0; j < e_n; j++) exp_q.push_back('{data: e_data[j], cyc: c0 + e_off[j]});
      end
    end
    start     = 1'b0;
    abort     = 1'b0;
    fifo_full = 1'b0;
    e_n       = 0;
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; e_n = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; fifo_full = 1'b0; din = 2'b00;
    cfg_div = '0; cfg_mode = '0; cfg_trig_mask = '0; cfg_trig_val = '0; cfg_words = '0;
    fill(2'b00);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_wen", 32'(fifo_wen), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Immediate capture, two words
    fill(2'b00);
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3;
    seq[4] = 2'd3; seq[5] = 2'd2; seq[6] = 2'd1; seq[7] = 2'd0;
    expect_w(8'h1B, 4);
    expect_w(8'hE4, 8);
    run(0, 0, 2'b00, 2'b00, 2, 99, 99, -99, 12);
    chk("imm_done", 32'(done), 32'h1);
    chk("imm_busy", 32'(busy), 32'h0);
    chk("imm_drain", 32'(exp_q.size()), 32'h0);

    // Divider 3: ticks every 4 clocks, first one 4 clocks after start
    fill(2'b10);
    expect_w(8'hAA, 16);
    run(3, 0, 2'b00, 2'b00, 1, 99, 99, -99, 20);
    chk("div_drain", 32'(exp_q.size()), 32'h0);

    // Pattern trigger on din_s == 3
    fill(2'b00);
    seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3;
    expect_w(8'hC0, 7);
    run(0, 1, 2'b11, 2'b11, 1, 99, 99, -99, 12);
    chk("pat_drain", 32'(exp_q.size()), 32'h0);

    // Change trigger on bit0 only; bit1 toggling must be ignored
    fill(2'b01);
    for (int i = 0; i < 10; i++) seq[i] = (i % 2 == 1) ? 2'b10 : 2'b00;
    expect_w(8'h55, 14);
    run(0, 2, 2'b01, 2'b00, 1, 99, 99, -99, 18);
    chk("chg_drain", 32'(exp_q.size()), 32'h0);

    // FIFO full during the second word: dropped, counted, overflow set
    fill(2'b11);
    for (int i = 0; i < 3; i++) seq[i] = 2'b00;
    seq[3] = 2'b01;
    for (int i = 4; i < 8; i++) seq[i] = 2'b10;
    expect_w(8'h01, 4);
    expect_w(8'hFF, 12);
    run(0, 0, 2'b00, 2'b00, 3, 6, 10, -99, 16);
    chk("full_ovf", 32'(overflow), 32'h1);
    chk("full_done", 32'(done), 32'h1);
    chk("full_drain", 32'(exp_q.size()), 32'h0);

    // Restart from DONE clears overflow
    fill(2'b01);
    expect_w(8'h55, 4);
    run(0, 0, 2'b00, 2'b00, 1, 99, 99, -99, 10);
    chk("restart_ovf", 32'(overflow), 32'h0);
    chk("restart_drain", 32'(exp_q.size()), 32'h0);

    // Abort after two captured samples: no write, back to IDLE
    fill(2'b01);
    run(0, 0, 2'b00, 2'b00, 1, 99, 99, 3, 10);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_drain", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset mid-capture
    fill(2'b10);
    run(0, 0, 2'b00, 2'b00, 1, 99, 99, -99, 3);
    chk("rstmid_busy_pre", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_dout", 32'(dout), 32'h0);
    chk("rstmid_wen", 32'(fifo_wen), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_done", 32'(done), 32'h0);
    chk("rstmid_ovf", 32'(overflow), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rstmid_idle", 32'(busy), 32'h0);

    // cfg_words = 0 behaves as one word
    fill(2'b11);
    expect_w(8'hFF, 4);
    run(0, 0, 2'b00, 2'b00, 0, 99, 99, -99, 10);
    chk("w0_done", 32'(done), 32'h1);
    chk("w0_drain", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
